// File: rtl/sobel_window.sv
// -----------------------------------------------------------------------------
// sobel_window
//
// Sliding 3x3 window generator that feeds the Sobel operator stage.
//
// The block takes a raster-order grayscale pixel stream and keeps the two
// previous image lines in line buffers. It also keeps a short column shift
// register holding the two most recent columns. For every interior pixel it
// emits one packed 3x3 neighbourhood through a single output register.
//
// Window packing:
//   slot k = c*3 + r occupies bits [k*PIX_W +: PIX_W]
//   c = 0 is the leftmost (oldest) column; r = 0 is the top (oldest) row.
//   The window emitted for the pixel accepted at (row, col) is centred on
//   (row-1, col-1).
//
// Parameters:
//   IMG_WIDTH   pixels per line (>= 3)
//   IMG_HEIGHT  lines per frame (>= 3)
//   PIX_W       bits per pixel
//   DWIDTH_OUT  packed window width, must equal 9*PIX_W
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   in_data    in   incoming pixel, raster order
//   in_valid   in   in_data valid
//   in_ready   out  block can accept a pixel this cycle
//   out_data   out  packed 3x3 window
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts the window this cycle
//   out_last   out  (only with SOBEL_WINDOW_LAST_EN) final window of the frame
//
// Optional feature macro: SOBEL_WINDOW_LAST_EN adds the out_last port.
// -----------------------------------------------------------------------------
module sobel_window #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int PIX_W      = 8,
    parameter int DWIDTH_OUT = 72
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PIX_W-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DWIDTH_OUT-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef SOBEL_WINDOW_LAST_EN
    ,
    output logic                  out_last
`endif
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int COLW = 3 * PIX_W;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    // Column word: the top row lives in the low bits, so concatenating
    // columns newest-first directly yields the slot layout c*3 + r.
    function automatic logic [COLW-1:0] pack_column(
        input logic [PIX_W-1:0] top,
        input logic [PIX_W-1:0] mid,
        input logic [PIX_W-1:0] bot
    );
        return {bot, mid, top};
    endfunction

    // Storage
    logic [PIX_W-1:0] r_line1 [IMG_WIDTH];   // previous row
    logic [PIX_W-1:0] r_line2 [IMG_WIDTH];   // row before that
    logic [COLW-1:0]  r_col_prev1;           // column accepted one pixel ago
    logic [COLW-1:0]  r_col_prev2;           // column accepted two pixels ago

    // Position of the pixel about to be accepted
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [CW-1:0] w_col_next;
    logic [RW-1:0] w_row_next;

    // Output register
    logic [DWIDTH_OUT-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;

    // Datapath/control wires
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_emit;
    logic                  w_last;
    logic [COLW-1:0]       w_col_new;
    logic [DWIDTH_OUT-1:0] w_window;

    // The output slot frees up either when empty or when it drains this cycle.
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;

    // New column: the two buffered rows above the current column plus the
    // incoming pixel at the bottom.
    assign w_col_new = pack_column(r_line2[r_col], r_line1[r_col], in_data);
    assign w_window  = {w_col_new, r_col_prev1, r_col_prev2};

    // The col gate also suppresses the two windows that would straddle the
    // previous line end at the start of every row.
    assign w_emit = w_accept && (r_row >= ROW_MIN) && (r_col >= COL_MIN);
    assign w_last = w_emit && (r_row == ROW_LAST) && (r_col == COL_LAST);

    // Next raster position: wraps per line and per frame with no gap.
    always_comb begin
        w_col_next = r_col;
        w_row_next = r_row;
        if (w_accept) begin
            if (r_col == COL_LAST) begin
                w_col_next = '0;
                if (r_row == ROW_LAST) begin
                    w_row_next = '0;
                end else begin
                    w_row_next = r_row + RW'(1);
                end
            end else begin
                w_col_next = r_col + CW'(1);
                w_row_next = r_row;
            end
        end else begin
            w_col_next = r_col;
            w_row_next = r_row;
        end
    end

    // Raster position counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            r_col <= w_col_next;
            r_row <= w_row_next;
        end
    end

    // Line buffers shift down one row at the current column. Their contents
    // need no reset because the row gate keeps stale data out of any window.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_line2[r_col] <= r_line1[r_col];
            r_line1[r_col] <= in_data;
        end
    end

    // Column shift register holding the two most recent columns.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_col_prev1 <= '0;
            r_col_prev2 <= '0;
        end else if (w_accept) begin
            r_col_prev2 <= r_col_prev1;
            r_col_prev1 <= w_col_new;
        end
    end

    // Single output register. Accepts happen only when the slot is free, so
    // a stalled window stays untouched until out_ready returns.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_window;
            r_out_last  <= w_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
`ifdef SOBEL_WINDOW_LAST_EN
    assign out_last  = r_out_last;
`else
    logic w_unused_last;
    assign w_unused_last = r_out_last;
`endif

endmodule
